// File: rtl/osd_pkg.sv
// Shared types for the OSD character-array write path: queued entry,
// arbiter state and grant encoding.
package osd_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } osd_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } osd_state_e;

  typedef enum logic {
    GNT_MENU   = 1'b0,
    GNT_STATUS = 1'b1
  } osd_grant_e;

endpackage

// File: rtl/osd_wr_fifo.sv
// Per-requester write FIFO; ready is registered from the next count so a
// same-cycle pop never raises it early, and it is held low in reset.
module osd_wr_fifo
  import osd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       vclk,
  input  logic       rst_i,
  input  logic       push,
  input  osd_entry_t din,
  input  logic       pop,
  output osd_entry_t dout_c,
  output logic       ready,
  output logic       empty_c,
  output logic       empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  osd_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign dout_c      = mem[rd_ptr];
  assign empty_c     = (count_q == '0);
  assign empty_nxt_c = (count_nxt == '0);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ready   <= (count_nxt != CNT_W'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge vclk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/osd_write_arbiter.sv
// Merges menu and status char-array writes into one registered write port,
// committing only during vertical blanking while not locked.
module osd_write_arbiter
  import osd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  MAX_ADDR   = 8'hEF
) (
  input  logic        vclk,
  input  logic        rst_i,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [7:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic [3:0]  m_be,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_addr,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_be,
  input  logic        vblank,
  input  logic        lock_i,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic        busy,
  output logic        drop_flag,
  input  logic        drop_clr
);

  osd_state_e state_q;
  osd_state_e state_nxt;
  osd_grant_e last_grant;

  osd_entry_t m_din, s_din, m_dout, s_dout, gnt_entry_c;
  logic m_push, s_push, m_drop, s_drop, m_store, s_store;
  logic m_pop, s_pop, pop_c, gnt_m_c;
  logic m_empty, s_empty, m_empty_nxt, s_empty_nxt;

  // Out-of-range writes are accepted but never reach a FIFO.
  assign m_push  = m_valid & m_ready;
  assign s_push  = s_valid & s_ready;
  assign m_drop  = m_push & (m_addr > MAX_ADDR);
  assign s_drop  = s_push & (s_addr > MAX_ADDR);
  assign m_store = m_push & ~m_drop;
  assign s_store = s_push & ~s_drop;

  assign m_din = '{addr: m_addr, data: m_data, be: m_be};
  assign s_din = '{addr: s_addr, data: s_data, be: s_be};

  assign m_pop = pop_c & gnt_m_c;
  assign s_pop = pop_c & ~gnt_m_c;

  osd_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_menu_fifo (
    .vclk        (vclk),
    .rst_i       (rst_i),
    .push        (m_store),
    .din         (m_din),
    .pop         (m_pop),
    .dout_c      (m_dout),
    .ready       (m_ready),
    .empty_c     (m_empty),
    .empty_nxt_c (m_empty_nxt)
  );

  osd_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_status_fifo (
    .vclk        (vclk),
    .rst_i       (rst_i),
    .push        (s_store),
    .din         (s_din),
    .pop         (s_pop),
    .dout_c      (s_dout),
    .ready       (s_ready),
    .empty_c     (s_empty),
    .empty_nxt_c (s_empty_nxt)
  );

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // State tracks the occupancy the FIFOs will have next cycle.
  always_comb begin
    state_nxt = IDLE;
    if (!m_empty_nxt || !s_empty_nxt) begin
      state_nxt = (vblank && !lock_i) ? DRAIN : WAIT;
    end
  end

  // Live vblank/lock gating stops pops on the cycle the window closes.
  always_comb begin
    pop_c       = 1'b0;
    gnt_m_c     = 1'b0;
    gnt_entry_c = s_dout;
    if (state_q == DRAIN && vblank && !lock_i) begin
      pop_c   = 1'b1;
      gnt_m_c = !m_empty && (s_empty || last_grant == GNT_STATUS);
    end
    if (gnt_m_c) gnt_entry_c = m_dout;
  end

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
      last_grant <= GNT_STATUS;
    end else begin
      wr_en <= pop_c;
      if (pop_c) begin
        wr_addr    <= gnt_entry_c.addr;
        wr_data    <= gnt_entry_c.data;
        wr_be      <= gnt_entry_c.be;
        last_grant <= gnt_m_c ? GNT_MENU : GNT_STATUS;
      end
    end
  end

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i)                drop_flag <= 1'b0;
    else if (m_drop | s_drop) drop_flag <= 1'b1;
    else if (drop_clr)        drop_flag <= 1'b0;
  end

  assign busy = !m_empty || !s_empty || wr_en;

endmodule
